// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg
// Shared types and constants for the SRAM to SRAM-like bridge.
// Contents:
//   state_e    - bridge FSM state (IDLE, WAIT_DATA, DONE)
//   SIZE_BYTE  - sram-like size code for a byte access
//   SIZE_HALF  - sram-like size code for a halfword access
//   SIZE_WORD  - sram-like size code for a word access
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_be_decode.sv
// sram_be_decode
// Purely combinational decode of SRAM byte enables into an sram-like
// access description.
// Ports:
//   i_wen     in  4  byte enables, 0000 = read
//   o_wr      out 1  1 = write
//   o_size    out 2  SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   o_addr_lo out 2  low address bits for the issued access
//   o_legal   out 1  0 when the enable pattern has no sram-like encoding
module sram_be_decode
  import sram_bridge_pkg::*;
(
  input  logic [3:0] i_wen,
  output logic       o_wr,
  output logic [1:0] o_size,
  output logic [1:0] o_addr_lo,
  output logic       o_legal
);

  always_comb begin
    o_wr      = |i_wen;
    o_size    = SIZE_WORD;
    o_addr_lo = 2'd0;
    o_legal   = 1'b1;
    case (i_wen)
      4'b0000: ;  // read: aligned word
      4'b0001: begin o_size = SIZE_BYTE; o_addr_lo = 2'd0; end
      4'b0010: begin o_size = SIZE_BYTE; o_addr_lo = 2'd1; end
      4'b0100: begin o_size = SIZE_BYTE; o_addr_lo = 2'd2; end
      4'b1000: begin o_size = SIZE_BYTE; o_addr_lo = 2'd3; end
      4'b0011: begin o_size = SIZE_HALF; o_addr_lo = 2'd0; end
      4'b1100: begin o_size = SIZE_HALF; o_addr_lo = 2'd2; end
      4'b1111: ;  // full word write
      // Unencodable patterns still go out as an aligned word write so the
      // pipeline never deadlocks; the caller flags the fault.
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_to_sram_like_bridge.sv
// sram_to_sram_like_bridge
// Converts a classic single-cycle SRAM pipeline port into an sram-like
// (addr_ok / data_ok handshake) request, stalling the pipeline until data
// returns and holding it in DONE while the whole pipeline stays frozen.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   sram_en/wen/addr/wdata  (in)     pipeline access request
//   sram_rdata, stall       (out)    captured read data, pipeline stall
//   req/wr/size/addr/wdata  (out)    sram-like request channel
//   addr_ok/data_ok/rdata   (in)     sram-like handshakes and read data
//   longest_stall           (in)     pipeline still frozen, keep DONE
//   error                   (out)    sticky fault flag
// Build option: SRAM_BRIDGE_TIMEOUT_EN enables a watchdog that forces DONE
// and sets error after TIMEOUT cycles without data.
module sram_to_sram_like_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_en,
  input  logic [3:0]        sram_wen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_wdata,
  output logic [31:0]       sram_rdata,
  output logic              stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  input  logic              longest_stall,
  output logic              error
);

  state_e      r_state;
  state_e      w_state_next;
  state_e      w_state_eff;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [1:0]  w_addr_lo;
  logic        w_legal;
  logic        w_accept;
  logic        w_capture;
  logic        w_wd_hit;
  logic        w_unused_addr_lo;

  // While rst is high the outputs already behave as in IDLE, so the
  // pipeline sees a clean request/stall picture during the reset cycle.
  assign w_state_eff = rst ? IDLE : r_state;

  assign req   = sram_en && (w_state_eff == IDLE);
  assign stall = sram_en && (w_state_eff != DONE);

  sram_be_decode u_be_decode (
    .i_wen     (sram_wen),
    .o_wr      (wr),
    .o_size    (size),
    .o_addr_lo (w_addr_lo),
    .o_legal   (w_legal)
  );

  assign addr  = {sram_addr[ADDR_W-1:2], w_addr_lo};
  assign wdata = sram_wdata;
  // The incoming low address bits are implied by the byte enables.
  assign w_unused_addr_lo = ^sram_addr[1:0];

  assign w_accept  = req && addr_ok;
  // data_ok only counts for the transaction actually in flight.
  assign w_capture = (r_state == IDLE && w_accept && data_ok) ||
                     (r_state == WAIT_DATA && data_ok);

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             w_wd_run;

  assign w_wd_run = (r_state == IDLE && req) || (r_state == WAIT_DATA);
  // Counter value k means k waiting cycles already elapsed; the edge that
  // would make it TIMEOUT moves the FSM to DONE instead.
  assign w_wd_hit = w_wd_run && (r_wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_wd_run || w_state_next == DONE) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  // Watchdog compiled out; TIMEOUT stays in the parameter list so both
  // builds share one instantiation.
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_wd_hit         = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_state_next = data_ok ? DONE : WAIT_DATA;
      WAIT_DATA: if (data_ok) w_state_next = DONE;
      DONE:      if (!longest_stall) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
    if (w_wd_hit) w_state_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_rdata <= rdata;
      if ((req && !w_legal) || w_wd_hit) r_error <= 1'b1;
    end
  end

  assign sram_rdata = r_rdata;
  assign error      = r_error;

endmodule

// File: tb/tb_sram_to_sram_like_bridge.sv
// tb_sram_to_sram_like_bridge
// Self-checking bench: directed scenarios plus randomized transactions
// compared against a transaction-level model of the bridge behaviour.
module tb_sram_to_sram_like_bridge;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          stall;
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [31:0]   rdata;
  logic          longest_stall;
  logic          error;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_txn    = 0;
  logic [31:0]   exp_rd;
  logic          exp_err;

  always #5 clk = ~clk;

  sram_to_sram_like_bridge #(.ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .sram_en       (sram_en),
    .sram_wen      (sram_wen),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .stall         (stall),
    .req           (req),
    .wr            (wr),
    .size          (size),
    .addr          (addr),
    .wdata         (wdata),
    .addr_ok       (addr_ok),
    .data_ok       (data_ok),
    .rdata         (rdata),
    .longest_stall (longest_stall),
    .error         (error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference view of the byte-enable rules: count enabled lanes and find
  // the lowest one, rather than listing patterns.
  task automatic be_model(input logic [3:0] w, output logic e_wr, output logic [1:0] e_sz,
                          output logic [1:0] e_lo, output logic e_ok);
    int pop;
    int low;
    pop  = $countones(w);
    low  = 0;
    for (int i = 3; i >= 0; i--) if (w[i]) low = i;
    e_wr = (w != 4'b0000);
    e_ok = (w == 4'b0000) || (pop == 1) || (w == 4'b0011) || (w == 4'b1100) || (w == 4'b1111);
    if (w == 4'b0000 || !e_ok) e_sz = 2'd2;
    else if (pop == 1)         e_sz = 2'd0;
    else if (pop == 2)         e_sz = 2'd1;
    else                       e_sz = 2'd2;
    e_lo = (e_ok && w != 4'b0000) ? low[1:0] : 2'd0;
  endtask

  // One pipeline access: aw cycles before addr_ok, data_ok d cycles after
  // the address handshake (0 = same cycle), then hold cycles of
  // longest_stall in DONE. Optionally preceded by a withdrawn request.
  task automatic txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                     input int aw, input int d, input int hold, input logic [31:0] rd,
                     input bit wdraw);
    logic       e_wr;
    logic [1:0] e_sz;
    logic [1:0] e_lo;
    logic       e_ok;
    be_model(w, e_wr, e_sz, e_lo, e_ok);
    addr_ok = 1'b0; data_ok = 1'b0; longest_stall = 1'b0;
    if (wdraw) begin
      sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = a;
      #1 check("wdraw_req_on", req, 1'b1);
      tick();
      sram_en = 1'b0; data_ok = 1'b1; rdata = $urandom;
      #1 check("wdraw_req_off", req, 1'b0);
      check("wdraw_stall", stall, 1'b0);
      tick();
      data_ok = 1'b0;
      #1 check("wdraw_rdata_ignored", sram_rdata, exp_rd);
    end
    sram_en = 1'b1; sram_wen = w; sram_addr = a; sram_wdata = wd;
    for (int i = 0; i < aw; i++) begin
      #1 check("pre_req", req, 1'b1);
      check("pre_stall", stall, 1'b1);
      tick();
    end
    addr_ok = 1'b1; data_ok = (d == 0); rdata = (d == 0) ? rd : $urandom;
    #1 check("acc_req", req, 1'b1);
    check("acc_wr", wr, e_wr);
    check("acc_size", size, e_sz);
    check("acc_addr", addr, {a[31:2], e_lo});
    check("acc_wdata", wdata, wd);
    check("acc_stall", stall, 1'b1);
    tick();
    addr_ok = 1'b0;
    if (d > 0) begin
      for (int i = 1; i < d; i++) begin
        data_ok = 1'b0; rdata = $urandom;
        #1 check("wait_req", req, 1'b0);
        check("wait_stall", stall, 1'b1);
        tick();
      end
      data_ok = 1'b1; rdata = rd;
      #1 check("data_stall", stall, 1'b1);
      tick();
    end
    exp_rd = rd;
    if (!e_ok) exp_err = 1'b1;
    for (int i = 0; i < hold; i++) begin
      longest_stall = 1'b1; data_ok = 1'($urandom_range(0, 1)); rdata = $urandom;
      #1 check("hold_stall", stall, 1'b0);
      check("hold_req", req, 1'b0);
      tick();
    end
    longest_stall = 1'b0; data_ok = 1'b0;
    #1 check("done_stall", stall, 1'b0);
    check("done_req", req, 1'b0);
    tick();
    #1 check("rearm_req", req, 1'b1);
    check("end_rdata", sram_rdata, exp_rd);
    check("end_error", error, exp_err);
    sram_en = 1'b0;
    $display("txn %0d wen=%b addr=%h aw=%0d dly=%0d hold=%0d rdata=%h", n_txn, w, a, aw, d, hold, rd);
    n_txn++;
  endtask

  logic [3:0] legal_wen [8];

  initial begin
    legal_wen = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'b0000; sram_addr = '0; sram_wdata = '0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0; longest_stall = 1'b0;
    exp_rd = 32'd0; exp_err = 1'b0;
    tick(); tick();
    sram_en = 1'b1;
    #1 check("rst_req", req, 1'b1);
    check("rst_stall", stall, 1'b1);
    check("rst_rdata", sram_rdata, 32'd0);
    check("rst_error", error, 1'b0);
    tick();
    rst = 1'b0; sram_en = 1'b0;

    // read with data three cycles after the address handshake
    txn(4'b0000, 32'h1000_0006, 32'h0, 0, 3, 0, 32'hCAFE_F00D, 1'b0);
    // halfword write, both handshakes together
    txn(4'b1100, 32'h0000_0020, 32'h1234_5678, 0, 0, 0, 32'h0BAD_0BAD, 1'b0);
    // read finished while the pipeline stays frozen five more cycles
    txn(4'b0000, 32'h0000_0100, 32'h0, 1, 1, 5, 32'h5555_AAAA, 1'b0);

    for (int n = 0; n < 30; n++) begin
      txn(legal_wen[$urandom_range(0, 7)], $urandom, $urandom, $urandom_range(0, 2),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
    end

    // unencodable enables: word write, sticky error
    txn(4'b0101, 32'h0000_0043, 32'hDEAD_BEEF, 0, 1, 0, 32'h7777_0000, 1'b0);
    for (int n = 0; n < 8; n++) begin
      txn(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2),
          $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'b0);
    end

    // reset in WAIT_DATA, then a late data_ok
    sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = 32'h0000_0200; addr_ok = 1'b1; data_ok = 1'b0;
    tick();
    addr_ok = 1'b0;
    #1 check("abort_wait_stall", stall, 1'b1);
    check("abort_wait_req", req, 1'b0);
    tick();
    rst = 1'b1;
    #1 check("abort_rst_req", req, 1'b1);
    check("abort_rst_stall", stall, 1'b1);
    tick();
    rst = 1'b0; data_ok = 1'b1; rdata = 32'hAAAA_5555;
    exp_rd = 32'd0; exp_err = 1'b0;
    #1 check("abort_idle_req", req, 1'b1);
    check("abort_rdata", sram_rdata, exp_rd);
    check("abort_error", error, exp_err);
    tick();
    data_ok = 1'b0; sram_en = 1'b0;
    #1 check("abort_late_ignored", sram_rdata, exp_rd);
    $display("txn %0d reset-abort in WAIT_DATA", n_txn);
    n_txn++;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
    sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = 32'h0000_0300; addr_ok = 1'b1;
    #1 check("wd_req", req, 1'b1);
    tick();
    addr_ok = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1 check("wd_wait_stall", stall, 1'b1);
      tick();
    end
    #1 check("wd_stall_release", stall, 1'b0);
    check("wd_error", error, 1'b1);
    sram_en = 1'b0;
    tick();
    $display("txn %0d watchdog timeout", n_txn);
    n_txn++;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_to_sram_like_bridge.md
SRAM_TO_SRAM_LIKE_BRIDGE -- requirements
Module: sram_to_sram_like_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of both sides.
REQ-002 SHALL have parameter TIMEOUT, default 256: watchdog limit in cycles (used only under REQ-030).
REQ-003 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sram_en  in  1  pipeline access request
- sram_wen  in  4  byte enables; 0000 = read
- sram_addr  in  ADDR_W  byte address
- sram_wdata  in  32  store data
- sram_rdata  out  32  captured read data
- stall  out  1  pipeline stall
- req  out  1  sram-like request
- wr  out  1  1 = write
- size  out  2  0 = byte, 1 = half, 2 = word
- addr  out  ADDR_W  sram-like address
- wdata  out  32  sram-like write data
- addr_ok  in  1  address handshake
- data_ok  in  1  data handshake
- rdata  in  32  sram-like read data
- longest_stall  in  1  whole pipeline still frozen
- error  out  1  sticky fault flag

Function
REQ-004 SHALL implement FSM states IDLE, WAIT_DATA, DONE.
REQ-005 req SHALL equal sram_en AND state==IDLE, combinationally.
REQ-006 IDLE with req & addr_ok & ~data_ok SHALL go to WAIT_DATA; with req & addr_ok & data_ok (same cycle) SHALL go to DONE; otherwise stay IDLE.
REQ-007 WAIT_DATA with data_ok SHALL go to DONE; otherwise stay.
REQ-008 DONE with ~longest_stall SHALL go to IDLE; otherwise stay.
REQ-009 sram_rdata SHALL load rdata on every cycle data_ok is high in IDLE (accepted) or WAIT_DATA, and hold otherwise.
REQ-010 data_ok arriving in DONE, or in IDLE without accepted request, SHALL be ignored.
REQ-011 stall SHALL equal sram_en AND state!=DONE, so the earliest stall release is the cycle after data_ok.
REQ-012 Reads (wen 0000): wr=0, size=2, addr = sram_addr with bits[1:0] forced 00.
REQ-013 Writes: wr=1, wdata=sram_wdata; wen 0001/0010/0100/1000 -> size 0, addr[1:0]=0/1/2/3; 0011/1100 -> size 1, addr[1:0]=0/2; 1111 -> size 2, addr[1:0]=0.
REQ-014 Any other nonzero wen SHALL be issued as a word write at the aligned address and SHALL set error.
REQ-015 addr[ADDR_W-1:2] SHALL always equal sram_addr[ADDR_W-1:2].
REQ-016 Deassertion of sram_en in IDLE before addr_ok SHALL withdraw req with no state change.

Reset
REQ-017 rst SHALL force state IDLE, sram_rdata 0, error 0, and the watchdog counter 0 on the next edge, aborting any transaction.
REQ-018 Outputs during reset SHALL be: req follows REQ-005 with IDLE; stall = sram_en.

Configuration
REQ-030 With SRAM_BRIDGE_TIMEOUT_EN defined: a counter SHALL increment each cycle in IDLE with req high or in WAIT_DATA, clear on entering DONE; reaching TIMEOUT SHALL set error and force DONE.
REQ-031 Without SRAM_BRIDGE_TIMEOUT_EN: no counter SHALL exist, and error SHALL be driven only by REQ-014.

Structure
REQ-040 Package sram_bridge_pkg SHALL hold the state enum and the SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
REQ-041 Sub-module sram_be_decode SHALL be combinational and map wen to {wr, size, addr_lo, legal}.

Verification
REQ-050 Read to 0x1000_0006, addr_ok at cycle 0, data_ok with rdata 0xCAFEF00D at cycle 3 -> addr 0x1000_0004, size 2, stall low at cycle 4, sram_rdata 0xCAFEF00D.
REQ-051 Write wen 1100, addr 0x20, with addr_ok and data_ok in the same cycle -> one req cycle, wr 1, size 1, addr 0x22, DONE next cycle.
REQ-052 Read done with longest_stall held 5 more cycles -> no second req; req re-asserts the cycle after longest_stall falls.
REQ-053 wen 0101 -> size 2, addr[1:0]=00, error stays 1 until rst.
REQ-054 rst asserted in WAIT_DATA, then late data_ok -> state IDLE, sram_rdata 0, late data_ok ignored.
REQ-055 SRAM_BRIDGE_TIMEOUT_EN, TIMEOUT=8, addr_ok and no data_ok -> error 1 and stall low 8 cycles after req.
